// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and related schedulers.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  localparam int STAT_W = 16;

  // Ceiling log2, floored at 1 so that index/counter widths are never zero.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) begin
        idx_o = IW'(j);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter with per-packet grant lock and burst cap in front of an async FIFO.
// Optional per-requester saturating beat counters are enabled by FIFO_WR_ARB_STATS_EN.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DSIZE-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [DSIZE-1:0]         wdata,
  output logic                     winc,
  input  logic                     wfull,
  output logic [clog2(NREQ)-1:0]   grant_id,
  output logic                     busy,
  output logic [NREQ*STAT_W-1:0]   stat_cnt
);

  localparam int IW  = clog2(NREQ);
  localparam int BCW = clog2(MAX_BURST + 1);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;

  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [IW-1:0]   sel;
  logic            accept;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + IW'(1);
  endfunction

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // wfull blocks acceptance outright, so a stalled cycle leaves every register untouched.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    sel        = pick_idx;
    accept     = 1'b0;
    if (state_q == ST_IDLE) begin
      accept = pick_any & ~wfull;
      if (accept) begin
        if (req_last[pick_idx] || MAX_BURST == 1) begin
          rr_ptr_d = next_idx(pick_idx);
        end else begin
          state_d    = ST_LOCK;
          owner_d    = pick_idx;
          beat_cnt_d = BCW'(1);
        end
      end
    end else begin
      sel    = owner_q;
      accept = req_valid[owner_q] & ~wfull;
      if (accept) begin
        if (req_last[owner_q] || beat_cnt_q == BURST_LAST) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = next_idx(owner_q);
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + BCW'(1);
        end
      end
    end
  end

  always_comb begin
    winc      = accept & wrst_n;
    busy      = wrst_n & (state_q == ST_LOCK);
    grant_id  = wrst_n ? sel : '0;
    wdata     = wrst_n ? req_data[int'(sel)*DSIZE +: DSIZE] : '0;
    req_ready = '0;
    if (winc) req_ready[sel] = 1'b1;
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NREQ];

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) stat_q[i] <= sat_inc(stat_q[i]);
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NREQ; i++) stat_cnt[i*STAT_W +: STAT_W] = stat_q[i];
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed plus randomized bench for fifo_wr_arb against a packet-level round-robin model.
module tb_fifo_wr_arb;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 32;
  localparam int MAX_BURST = 8;
  localparam int IW        = 2;

  logic                  wclk;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [DSIZE-1:0]      wdata;
  logic                  winc;
  logic                  wfull;
  logic [IW-1:0]         grant_id;
  logic                  busy;
  logic [NREQ*16-1:0]    stat_cnt;

  int tests;
  int fails;

  // Model: who (if anyone) holds the port, beats given in the current grant, next search start.
  int m_owner;
  int m_beats;
  int m_rr;
  int m_stat [NREQ];
  int exp_win;

  int gq[$];

  fifo_wr_arb #(
    .NREQ      (NREQ),
    .DSIZE     (DSIZE),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wdata     (wdata),
    .winc      (winc),
    .wfull     (wfull),
    .grant_id  (grant_id),
    .busy      (busy),
    .stat_cnt  (stat_cnt)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_rr    = 0;
    for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = $urandom;
  endtask

  // Settle, predict this cycle's grant from the model, compare all outputs.
  task automatic sample_check();
    logic found;
    #1;
    exp_win = -1;
    found   = 1'b0;
    if (wrst_n && !wfull) begin
      if (m_owner >= 0) begin
        if (req_valid[m_owner]) exp_win = m_owner;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          if (!found && req_valid[(m_rr + k) % NREQ]) begin
            exp_win = (m_rr + k) % NREQ;
            found   = 1'b1;
          end
        end
      end
    end
    chk("winc", winc, exp_win >= 0);
    chk("req_ready", req_ready, (exp_win >= 0) ? (64'd1 << exp_win) : 64'd0);
    chk("busy", busy, wrst_n && (m_owner >= 0));
    if (!wrst_n) begin
      chk("rst_wdata", wdata, 0);
      chk("rst_grant", grant_id, 0);
    end
    if (exp_win >= 0) begin
      chk("grant_id", grant_id, exp_win);
      chk("wdata", wdata, req_data[exp_win*DSIZE +: DSIZE]);
    end
  endtask

  task automatic advance();
    @(posedge wclk);
    if (wrst_n && exp_win >= 0) begin
      m_beats++;
      if (m_stat[exp_win] < 16'hFFFF) m_stat[exp_win]++;
      if (req_last[exp_win] || m_beats == MAX_BURST) begin
        m_owner = -1;
        m_beats = 0;
        m_rr    = (exp_win + 1) % NREQ;
      end else begin
        m_owner = exp_win;
      end
    end
    #1;
  endtask

  task automatic step();
    sample_check();
    advance();
  endtask

  task automatic check_stats(input string tag);
    for (int i = 0; i < NREQ; i++) begin
`ifdef FIFO_WR_ARB_STATS_EN
      chk(tag, stat_cnt[i*16 +: 16], m_stat[i]);
`else
      chk(tag, stat_cnt[i*16 +: 16], 0);
`endif
    end
  endtask

  initial begin
    int s;
    int run;
    int b0;
    tests = 0;
    fails = 0;
    model_reset();

    // Reset: outputs forced low even with every requester valid.
    wrst_n    = 1'b0;
    wfull     = 1'b0;
    req_valid = '1;
    req_last  = '1;
    rand_data();
    step();
    step();
    wrst_n = 1'b1;

    // All requesters single-beat: strict rotation 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      rand_data();
      sample_check();
      chk("rr_seq", grant_id, i % NREQ);
      chk("rr_winc", winc, 1);
      advance();
    end

    // Req1 sends a 3-beat packet while req0/req2 also wait.
    req_valid = 4'b0111;
    req_last  = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) req_last = 4'b0111;
      rand_data();
      sample_check();
      chk("pkt_grant", grant_id, (i < 3) ? 1 : 2);
      chk("pkt_busy", busy, (i == 1 || i == 2));
      advance();
    end

    // Req0 streams without last; burst cap forces a hand-off to req3.
    req_valid = 4'b1001;
    req_last  = 4'b1000;
    gq.delete();
    b0 = 0;
    for (int c = 0; c < 40 && b0 < 12; c++) begin
      rand_data();
      sample_check();
      if (winc) begin
        gq.push_back(int'(grant_id));
        if (grant_id == 0) b0++;
      end
      advance();
    end
    chk("stream_done", b0, 12);
    s = 0;
    while (s < gq.size() && gq[s] != 0) s++;
    run = 0;
    while (s + run < gq.size() && gq[s + run] == 0) run++;
    chk("burst_cap", run, MAX_BURST);
    chk("after_cap", (s + run < gq.size()) ? gq[s + run] : -1, 3);
    // Finish req0's packet so the next phase starts unlocked.
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    for (int c = 0; c < 3; c++) step();

    // wfull stalls a locked owner for 3 cycles; lock survives.
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      wfull = (i >= 2 && i <= 4);
      if (i == 5) req_last = 4'b0100;
      rand_data();
      sample_check();
      chk("stall_winc", winc, !wfull);
      chk("stall_busy", busy, i >= 1);
      chk("stall_owner", grant_id, 2);
      advance();
    end
    wfull = 1'b0;

    // Reset while req1 holds the lock; afterwards req0 wins first.
    req_valid = 4'b0010;
    req_last  = 4'b0000;
    step();
    step();
    wrst_n = 1'b0;
    #1;
    chk("mid_rst_winc", winc, 0);
    chk("mid_rst_busy", busy, 0);
    model_reset();
    step();
    check_stats("stat_rst");
    wrst_n    = 1'b1;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    sample_check();
    chk("post_rst_grant", grant_id, 0);
    advance();

    // Randomized traffic with occasional back-pressure.
    for (int c = 0; c < 2000; c++) begin
      req_valid = NREQ'($urandom);
      req_last  = NREQ'($urandom);
      wfull     = ($urandom_range(0, 7) == 0);
      rand_data();
      step();
    end
    wfull = 1'b0;
    check_stats("stat_rand");

`ifdef FIFO_WR_ARB_STATS_EN
    // Drive req2 far past the 16-bit counter range.
    req_valid = 4'b0100;
    for (int c = 0; c < 70000; c++) begin
      req_last = NREQ'($urandom);
      rand_data();
      step();
    end
    chk("stat_sat", stat_cnt[2*16 +: 16], 16'hFFFF);
    check_stats("stat_final");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Write-side arbiter that shares the single write port of the 32x32 async FIFO (fifo1 instance) among NREQ requesters in the write clock domain.
- Round-robin selection between packets, with the grant locked to one requester until its last beat or a burst cap.
- Drives winc/wdata and observes wfull. Sits between the write-domain producers and the FIFO.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DSIZE, 32, data width; matches FIFO DSIZE.
- MAX_BURST, 8, maximum beats per grant before forced re-arbitration (>=1).

Ports:
- wclk  input  1  write-domain clock.
- wrst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester beat valid.
- req_last  input  NREQ  per-requester last beat of packet.
- req_data  input  NREQ*DSIZE  requester data; requester i occupies bits [i*DSIZE +: DSIZE].
- req_ready  output  NREQ  beat accepted this cycle (one-hot or zero).
- wdata  output  DSIZE  to FIFO wdata.
- winc  output  1  to FIFO winc.
- wfull  input  1  from FIFO wfull.
- grant_id  output  clog2(NREQ)  index of the requester served this cycle; valid when winc=1.
- busy  output  1  high while a packet lock is held.
- stat_cnt  output  NREQ*16  per-requester accepted-beat counters (see Optional Feature).

Behaviour:
- Clock and reset: one clock, wclk. Reset is asynchronous and active-low on wrst_n. Reset sets state=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
- Outputs during reset: while wrst_n=0, winc=0, req_ready=0, busy=0, wdata=0 and grant_id=0. These are gated combinationally.
- Latency: zero-cycle, combinational grant. A beat transfers in the cycle where req_valid[i]=1 and req_ready[i]=1. That is the same cycle winc=1 and the FIFO captures on the wclk edge.
- wfull: any cycle with wfull=1 forces winc=0 and req_ready=0. No state change, no pointer movement.
- State machine, 2 states:
  - IDLE: when wfull=0 and any req_valid is set, the winner is the first valid index at or after rr_ptr, searching upward modulo NREQ. Set winc=1, wdata=req_data[winner], req_ready[winner]=1, grant_id=winner.
    - If req_last[winner]=1 or MAX_BURST=1: stay IDLE, rr_ptr<=(winner+1)%NREQ.
    - Otherwise: go to LOCK with owner<=winner and beat_cnt<=1.
  - LOCK: serve only the owner. winc=req_valid[owner]&~wfull. All other req_ready are 0. grant_id=owner. busy=1.
    - On each accepted beat, beat_cnt++.
    - If req_last[owner]=1 or beat_cnt+1==MAX_BURST: go to IDLE, rr_ptr<=(owner+1)%NREQ, beat_cnt<=0.
    - If the owner drops req_valid, the lock holds indefinitely (no timeout).
- Boundary conditions:
  - rr_ptr wraps NREQ-1 -> 0.
  - beat_cnt width is clog2(MAX_BURST+1).
  - The single-beat packet case is handled entirely in IDLE.
  - wfull rising mid-packet stalls the owner; the lock is kept.
- Reset mid-packet: returns to IDLE immediately and the partial packet is abandoned. Protocol recovery is the requesters' job.
- Illegal or unused: req_last is ignored when the matching req_valid=0.

Optional Feature:
- Macro FIFO_WR_ARB_STATS_EN.
- Defined: stat_cnt holds NREQ 16-bit counters. Counter i increments on each accepted beat from requester i and saturates at 16'hFFFF. All counters reset to 0 on wrst_n.
- Undefined: no counter registers; stat_cnt is tied to 0. The port list is unchanged so benches are shared.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state encoding constants ST_IDLE=1'b0 and ST_LOCK=1'b1;
  - the STAT_W=16 constant;
  - a clog2 function.
- One sub-module, rr_pick: a combinational round-robin priority picker (inputs req vector and rr_ptr; outputs winner index and any_valid). Reused by future read-side schedulers.

Test Plan:
- Reset then NREQ=4, req_valid=4'b1111, all req_last=1, wfull=0 -> grant_id sequence 0,1,2,3,0; one beat per cycle; winc=1 every cycle.
- Req1 sends 3-beat packet (last on beat 3) while req0 and req2 are valid -> grant_id=1,1,1 consecutive, busy=1 for beats 2-3, then next grant to 2.
- Req0 streams 12 beats with no req_last, MAX_BURST=8 -> 8 beats accepted, forced IDLE, req3 (valid) served next, req0 resumes on a later turn.
- wfull=1 for 3 cycles during LOCK at beat 2 -> winc=0 and req_ready=0 for those cycles, owner retained, beat 3 accepted when wfull=0.
- Assert wrst_n=0 mid-LOCK -> winc and busy drop immediately; after release rr_ptr=0 and req0 is granted first.
- With FIFO_WR_ARB_STATS_EN, 70000 beats from req2 -> stat_cnt[2] saturates at 16'hFFFF; without the macro stat_cnt stays 0.
